// File: rtl/clint_wb.sv
// Core-local interruptor on the Wishbone data bus: msip, 64-bit mtimecmp and
// a free-running 64-bit mtime, with gated, prioritised requests to the core.
module clint_wb #(
    parameter int ADDR_W   = 16,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    input  logic [31:0]       latest_mie,
    input  logic [31:0]       latest_mstatus,
    output logic              interrupt_clint,
    output logic [30:0]       exception_code_clint,
    output logic              mtip_o,
    output logic              msip_o
);

    localparam logic [15:0]       TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] A_MSIP     = ADDR_W'(32'h0000_0000);
    localparam logic [ADDR_W-1:0] A_MTCMP_LO = ADDR_W'(32'h0000_4000);
    localparam logic [ADDR_W-1:0] A_MTCMP_HI = ADDR_W'(32'h0000_4004);
    localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(32'h0000_BFF8);
    localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(32'h0000_BFFC);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic              msip_q, msip_d;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtcmp_q, mtcmp_d;
    logic [15:0]       presc_q, presc_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              mtip_q, mtip_d;
    logic              msipo_q, msipo_d;
    logic              irq_q, irq_d;
    logic [30:0]       code_q, code_d;

    logic [ADDR_W-1:0] word_adr_s;
    logic              req_s, wr_s, tick_s, sw_req_s, tm_req_s;
    logic [31:0]       rdata_s;
    logic              unused_s;

    assign word_adr_s = {wb_adr_i[ADDR_W-1:2], 2'b00};
    assign unused_s   = ^{wb_adr_i[1:0], latest_mie[31:8], latest_mie[6:4],
                          latest_mie[2:0], latest_mstatus[31:4], latest_mstatus[2:0]};

    // Read mux over the register map.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (word_adr_s)
            A_MSIP:     rdata_s = {31'h0000_0000, msip_q};
            A_MTCMP_LO: rdata_s = mtcmp_q[31:0];
            A_MTCMP_HI: rdata_s = mtcmp_q[63:32];
            A_MTIME_LO: rdata_s = mtime_q[31:0];
            A_MTIME_HI: rdata_s = mtime_q[63:32];
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // Next-state: bus handshake, register writes, timebase and interrupt gating.
    always_comb begin
        req_s    = wb_cyc_i & wb_stb_i & ~ack_q;
        wr_s     = req_s & wb_we_i;
        tick_s   = (presc_q == TICK_LAST);
        sw_req_s = msipo_q & latest_mie[3];
        tm_req_s = mtip_q & latest_mie[7];

        ack_d   = req_s;
        dat_d   = (req_s & ~wb_we_i) ? rdata_s : 32'h0000_0000;
        presc_d = tick_s ? 16'h0000 : presc_q + 16'h0001;
        mtip_d  = (mtime_q >= mtcmp_q);
        msipo_d = msip_q;
        irq_d   = latest_mstatus[3] & (sw_req_s | tm_req_s);

        if (sw_req_s) begin
            code_d = 31'd3;
        end else if (tm_req_s) begin
            code_d = 31'd7;
        end else begin
            code_d = 31'd0;
        end

        if (wr_s && (word_adr_s == A_MSIP) && wb_sel_i[0]) begin
            msip_d = wb_dat_i[0];
        end else begin
            msip_d = msip_q;
        end

        mtcmp_d = mtcmp_q;
        if (wr_s && (word_adr_s == A_MTCMP_LO)) begin
            mtcmp_d[31:0] = merge_bytes(mtcmp_q[31:0], wb_dat_i, wb_sel_i);
        end else if (wr_s && (word_adr_s == A_MTCMP_HI)) begin
            mtcmp_d[63:32] = merge_bytes(mtcmp_q[63:32], wb_dat_i, wb_sel_i);
        end else begin
            mtcmp_d = mtcmp_q;
        end

        // A bus write to mtime swallows a coincident tick; no carry between halves.
        if (wr_s && (word_adr_s == A_MTIME_LO)) begin
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
        end else if (wr_s && (word_adr_s == A_MTIME_HI)) begin
            mtime_d = {merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
        end else if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_q  <= 1'b0;
            mtime_q <= 64'h0000_0000_0000_0000;
            mtcmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q <= 16'h0000;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0000_0000;
            mtip_q  <= 1'b0;
            msipo_q <= 1'b0;
            irq_q   <= 1'b0;
            code_q  <= 31'd0;
        end else begin
            msip_q  <= msip_d;
            mtime_q <= mtime_d;
            mtcmp_q <= mtcmp_d;
            presc_q <= presc_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            mtip_q  <= mtip_d;
            msipo_q <= msipo_d;
            irq_q   <= irq_d;
            code_q  <= code_d;
        end
    end

    assign wb_ack_o             = ack_q;
    assign wb_dat_o             = dat_q;
    assign mtip_o               = mtip_q;
    assign msip_o               = msipo_q;
    assign interrupt_clint      = irq_q;
    assign exception_code_clint = code_q;

endmodule

// File: tb/tb_clint_wb.sv
// Bench for clint_wb: fixed vectors, hand sequences for timing corners, and
// randomized traffic checked every cycle against a behavioural model.
module tb_clint_wb;

    localparam int TICK_DIV = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wb_adr = 16'h0000;
    logic [31:0] wb_dat_i = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'h0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic [31:0] latest_mie = 32'h0;
    logic [31:0] latest_mstatus = 32'h0;
    logic        interrupt_clint;
    logic [30:0] exception_code_clint;
    logic        mtip_o;
    logic        msip_o;

    clint_wb #(.ADDR_W(16), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
        .wb_ack_o(wb_ack),
        .latest_mie(latest_mie), .latest_mstatus(latest_mstatus),
        .interrupt_clint(interrupt_clint), .exception_code_clint(exception_code_clint),
        .mtip_o(mtip_o), .msip_o(msip_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the architectural state and the registered outputs.
    logic        m_msip;
    logic [63:0] m_mtime, m_cmp;
    int          m_presc;
    logic        m_ack, m_mtip, m_msipo, m_irq;
    logic [31:0] m_dat;
    logic [30:0] m_code;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_msip = 1'b0; m_mtime = 64'd0; m_cmp = '1; m_presc = 0;
        m_ack = 1'b0; m_dat = 32'h0; m_mtip = 1'b0; m_msipo = 1'b0;
        m_irq = 1'b0; m_code = 31'd0;
    endtask

    // Applies one clock edge of architectural rules to the model.
    task automatic model_edge();
        logic        req, tick, sw, tm;
        logic [15:0] a;
        logic [31:0] rd;
        logic [63:0] t_next;
        req  = wb_cyc && wb_stb && !m_ack;
        tick = (m_presc == TICK_DIV - 1);
        a    = {wb_adr[15:2], 2'b00};
        rd   = 32'h0;
        if (a == 16'h0000) rd = {31'd0, m_msip};
        else if (a == 16'h4000) rd = m_cmp[31:0];
        else if (a == 16'h4004) rd = m_cmp[63:32];
        else if (a == 16'hBFF8) rd = m_mtime[31:0];
        else if (a == 16'hBFFC) rd = m_mtime[63:32];
        sw = m_msipo & latest_mie[3];
        tm = m_mtip & latest_mie[7];
        m_irq  = latest_mstatus[3] & (sw | tm);
        m_code = sw ? 31'd3 : (tm ? 31'd7 : 31'd0);
        m_mtip  = (m_mtime >= m_cmp);
        m_msipo = m_msip;
        t_next = tick ? m_mtime + 64'd1 : m_mtime;
        if (req && wb_we) begin
            if (a == 16'h0000 && wb_sel[0]) m_msip = wb_dat_i[0];
            if (a == 16'h4000) m_cmp[31:0] = lanes(m_cmp[31:0], wb_dat_i, wb_sel);
            if (a == 16'h4004) m_cmp[63:32] = lanes(m_cmp[63:32], wb_dat_i, wb_sel);
            if (a == 16'hBFF8) t_next = {m_mtime[63:32], lanes(m_mtime[31:0], wb_dat_i, wb_sel)};
            if (a == 16'hBFFC) t_next = {lanes(m_mtime[63:32], wb_dat_i, wb_sel), m_mtime[31:0]};
        end
        m_mtime = t_next;
        m_presc = tick ? 0 : m_presc + 1;
        m_dat   = (req && !wb_we) ? rd : 32'h0;
        m_ack   = req;
    endtask

    task automatic check_outputs();
        check("ack", 64'(wb_ack), 64'(m_ack));
        check("dat_o", 64'(wb_dat_o), 64'(m_dat));
        check("mtip_o", 64'(mtip_o), 64'(m_mtip));
        check("msip_o", 64'(msip_o), 64'(m_msipo));
        check("interrupt", 64'(interrupt_clint), 64'(m_irq));
        check("code", 64'(exception_code_clint), 64'(m_code));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_outputs();
    endtask

    task automatic bus(input logic we, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] sel, output logic [31:0] rdata);
        int guard = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = a; wb_dat_i = d; wb_sel = sel;
        do begin
            step();
            guard++;
        end while (!wb_ack && guard < 8);
        check("ack_within_bound", 64'(wb_ack), 64'd1);
        rdata = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        step();
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] unused_rd;
        bus(1'b1, a, d, sel, unused_rd);
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, a, 32'h0, 4'hF, r);
        check(name, 64'(r), 64'(exp));
    endtask

    task automatic do_reset();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic        pat[3];
        int          guard;

        vecs[0]  = '{1'b0, 16'h0000, 32'h0,        4'hF,    32'h0000_0000};
        vecs[1]  = '{1'b0, 16'h4000, 32'h0,        4'hF,    32'hFFFF_FFFF};
        vecs[2]  = '{1'b0, 16'h4004, 32'h0,        4'hF,    32'hFFFF_FFFF};
        vecs[3]  = '{1'b1, 16'h4000, 32'hAABBCCDD, 4'b0011, 32'h0};
        vecs[4]  = '{1'b0, 16'h4000, 32'h0,        4'hF,    32'hFFFF_CCDD};
        vecs[5]  = '{1'b0, 16'h1234, 32'h0,        4'hF,    32'h0000_0000};
        vecs[6]  = '{1'b1, 16'h1234, 32'h12345678, 4'hF,    32'h0};
        vecs[7]  = '{1'b0, 16'h1234, 32'h0,        4'hF,    32'h0000_0000};
        vecs[8]  = '{1'b1, 16'h0000, 32'hFFFFFFFF, 4'h0,    32'h0};
        vecs[9]  = '{1'b0, 16'h0000, 32'h0,        4'hF,    32'h0000_0000};
        vecs[10] = '{1'b1, 16'h0000, 32'hFFFFFFFF, 4'hF,    32'h0};
        vecs[11] = '{1'b0, 16'h0000, 32'h0,        4'hF,    32'h0000_0001};
        vecs[12] = '{1'b1, 16'h4007, 32'h11223344, 4'b1100, 32'h0};
        vecs[13] = '{1'b0, 16'h4004, 32'h0,        4'hF,    32'h1122_FFFF};
        vecs[14] = '{1'b1, 16'h0003, 32'h00000000, 4'b0001, 32'h0};
        vecs[15] = '{1'b0, 16'h0002, 32'h0,        4'hF,    32'h0000_0000};
        vecs[16] = '{1'b0, 16'h8000, 32'h0,        4'hF,    32'h0000_0000};

        // Reset state and mtime counting from zero.
        do_reset();
        rd("mtime_lo_first", 16'hBFF8, 32'h0000_0000);
        rd("mtime_lo_second", 16'hBFF8, 32'h0000_0002);
        rd("mtime_hi_reset", 16'hBFFC, 32'h0000_0000);

        // Timer interrupt path.
        latest_mstatus = 32'h8; latest_mie = 32'h80;
        wr(16'h4004, 32'h0, 4'hF);
        wr(16'h4000, 32'h40, 4'hF);
        guard = 0;
        while (!mtip_o && guard < 200) begin step(); guard++; end
        check("mtip_rise", 64'(mtip_o), 64'd1);
        check("irq_lags_mtip", 64'(interrupt_clint), 64'd0);
        step();
        check("timer_irq", 64'(interrupt_clint), 64'd1);
        check("timer_code", 64'(exception_code_clint), 64'd7);
        wr(16'h4000, 32'hFFFF_FFFF, 4'hF);
        step();
        check("timer_irq_cleared", 64'(interrupt_clint), 64'd0);

        // Software beats timer.
        wr(16'h4000, 32'h0, 4'hF);
        step(); step();
        check("timer_code_again", 64'(exception_code_clint), 64'd7);
        latest_mie = 32'h88;
        wr(16'h0000, 32'h1, 4'hF);
        step();
        check("sw_priority_code", 64'(exception_code_clint), 64'd3);
        wr(16'h0000, 32'h0, 4'hF);
        step();
        check("back_to_timer_code", 64'(exception_code_clint), 64'd7);

        // mstatus.MIE gating.
        latest_mie = 32'h8; latest_mstatus = 32'h0;
        wr(16'h0000, 32'h1, 4'hF);
        step(); step();
        check("gated_irq", 64'(interrupt_clint), 64'd0);
        check("gated_msip_o", 64'(msip_o), 64'd1);
        latest_mstatus = 32'h8;
        step();
        check("ungated_irq", 64'(interrupt_clint), 64'd1);
        check("ungated_code", 64'(exception_code_clint), 64'd3);
        latest_mstatus = 32'h0; latest_mie = 32'h0;

        // Register map and byte-lane vectors.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].we) wr(vecs[i].adr, vecs[i].dat, vecs[i].sel);
            else rd($sformatf("vec%0d_read", i), vecs[i].adr, vecs[i].exp);
        end

        // Held strobe: acks alternate.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 16'h1234;
        check("held_ack_pre", 64'(wb_ack), 64'd0);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("held_ack_%0d", i), 64'(wb_ack), 64'(pat[i]));
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        step();

        // Write collides with tick: no carry into hi, then natural carry later.
        do_reset();
        wr(16'hBFFC, 32'h5, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFF0, 4'hF);
        rd("collide_hi_kept", 16'hBFFC, 32'h0000_0005);
        rd("collide_lo_count", 16'hBFF8, 32'hFFFF_FFF3);
        for (int i = 0; i < 20; i++) step();
        rd("carry_hi", 16'hBFFC, 32'h0000_0006);

        // 64-bit wrap against mtimecmp = all ones.
        do_reset();
        wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        check("wrap_mtip_before", 64'(mtip_o), 64'd0);
        step();
        check("wrap_mtip_at_max", 64'(mtip_o), 64'd1);
        step();
        check("wrap_mtip_after", 64'(mtip_o), 64'd0);
        rd("wrap_lo", 16'hBFF8, 32'h0000_0001);
        rd("wrap_hi", 16'hBFFC, 32'h0000_0000);

        // Reset in the middle of an acknowledged transfer.
        wr(16'h4004, 32'h1234_5678, 4'hF);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 16'h4004;
        step();
        check("midreset_ack_before", 64'(wb_ack), 64'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("midreset_ack_drop", 64'(wb_ack), 64'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        step();
        rst = 1'b0;
        rd("midreset_cmp_hi", 16'h4004, 32'hFFFF_FFFF);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            case ($urandom_range(0, 5))
                0: a = 16'h0000;
                1: a = 16'h4000;
                2: a = 16'h4004;
                3: a = 16'hBFF8;
                4: a = 16'hBFFC;
                default: a = 16'($urandom);
            endcase
            a[1:0] = 2'($urandom);
            latest_mie = $urandom;
            latest_mstatus = $urandom;
            bus(1'($urandom), a, $urandom, 4'($urandom), r);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
